// File: rtl/systolic_feeder_pkg.sv
// Shared types and sizing helpers for the systolic skew feeder.
package systolic_feeder_pkg;

  typedef enum logic [1:0] {IDLE, LOADED, DRAIN} feeder_state_t;

  function automatic int unsigned feeder_last(input int unsigned depth,
                                              input int unsigned channels);
    return depth + channels - 2;
  endfunction

  // A step counter must hold 0..LAST; a 1x1 array still needs one bit.
  function automatic int unsigned feeder_kw(input int unsigned depth,
                                            input int unsigned channels);
    return (depth + channels - 1 > 1) ? $clog2(depth + channels - 1) : 1;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One output lane of the skew feeder: stores DEPTH elements and emits
// element (k - LANE) while the drain is advancing.
module skew_lane
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BITS  = 8,
  parameter int unsigned LANE  = 0,
  parameter int unsigned KW    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic signed [BITS-1:0] din [DEPTH],
  input  logic                   active,
  input  logic [KW-1:0]          k,
  output logic signed [BITS-1:0] q,
  output logic                   q_valid
);

  logic signed [BITS-1:0] tile [DEPTH];
  logic [31:0]            off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) tile[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < DEPTH; i++) tile[i] <= din[i];
    end
  end

  // k < LANE wraps off to a huge value, so one bound check covers both sides.
  always_comb begin
    off     = 32'(k) - LANE;
    q       = '0;
    q_valid = 1'b0;
    if (active && off < DEPTH) begin
      q_valid = 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (off == i) q = tile[i];
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skewed multi-lane tile feeder for a systolic array edge.
// Optional shadow tile: define SKEW_FEEDER_DOUBLE_BUFFER_EN.
module systolic_skew_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BITS     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic signed [BITS-1:0] load_data [CHANNELS][DEPTH],
  input  logic                   start,
  input  logic                   en,
  output logic signed [BITS-1:0] q [CHANNELS],
  output logic [CHANNELS-1:0]    q_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned KW     = feeder_kw(DEPTH, CHANNELS);
  localparam int unsigned LAST   = feeder_last(DEPTH, CHANNELS);
  localparam logic [KW-1:0] K_LAST = KW'(LAST);

  feeder_state_t          state, next_state;
  logic [KW-1:0]          k;
  logic                   active, load_hs, tile_we, refill;
  logic signed [BITS-1:0] lane_din [CHANNELS][DEPTH];

  assign busy    = (state == DRAIN);
  assign active  = busy && en;
  assign done    = active && (k == K_LAST);
  assign load_hs = load_valid && load_ready;

`ifdef SKEW_FEEDER_DOUBLE_BUFFER_EN
  logic                   shadow_full, promote;
  logic signed [BITS-1:0] shadow [CHANNELS][DEPTH];

  assign load_ready = rst_n && ((state == IDLE) || !shadow_full);
  assign promote    = done && shadow_full;
  // A load landing exactly on the final step bypasses the shadow.
  assign tile_we    = (load_hs && ((state == IDLE) || done)) || promote;
  assign refill     = shadow_full || load_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_full <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned i = 0; i < DEPTH; i++) shadow[c][i] <= '0;
    end else if (promote) begin
      shadow_full <= 1'b0;
    end else if (load_hs && state != IDLE && !done) begin
      shadow_full <= 1'b1;
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned i = 0; i < DEPTH; i++) shadow[c][i] <= load_data[c][i];
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++)
      for (int unsigned i = 0; i < DEPTH; i++)
        lane_din[c][i] = promote ? shadow[c][i] : load_data[c][i];
  end
`else
  assign load_ready = rst_n && (state == IDLE);
  assign tile_we    = load_hs;
  assign refill     = 1'b0;

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++)
      for (int unsigned i = 0; i < DEPTH; i++) lane_din[c][i] = load_data[c][i];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load_hs) next_state = LOADED;
      LOADED:  if (start)   next_state = DRAIN;
      DRAIN:   if (done)    next_state = refill ? LOADED : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              k <= '0;
    else if (!busy || done)  k <= '0;
    else if (active)         k <= k + 1'b1;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    skew_lane #(
      .DEPTH(DEPTH),
      .BITS (BITS),
      .LANE (c),
      .KW   (KW)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (tile_we),
      .din    (lane_din[c]),
      .active (active),
      .k      (k),
      .q      (q[c]),
      .q_valid(q_valid[c])
    );
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Multi-channel preload buffer that feeds one edge of the systolic matrix-multiply array. A full CHANNELS×DEPTH operand tile is captured in one handshake, then drained one element per channel per enabled cycle. Channel c is delayed by c cycles, so the array receives the diagonal wavefront it needs. It replaces the single-lane fixed-depth preload FIFO with parametrised width, depth and channel count, a load/start/done handshake, stall support and per-channel valid flags.

## Interface
- CHANNELS, default 8: number of output lanes (array rows); ≥1
- DEPTH, default 8: elements per lane per tile; ≥1
- BITS, default 8: signed element width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  tile present on load_data
- load_ready  output  1  tile can be accepted this cycle
- load_data  input  signed [BITS-1:0] [CHANNELS][DEPTH]  tile; load_data[c][i] is element i of lane c
- start  input  1  begin draining the loaded tile
- en  input  1  advance enable (array not stalled)
- q  output  signed [BITS-1:0] [CHANNELS]  lane outputs
- q_valid  output  [CHANNELS]  lane carries a real element
- busy  output  1  state is DRAIN
- done  output  1  one-cycle pulse on the final drain step

## Operation
- FSM states:
  - IDLE → LOADED on a load handshake (load_valid && load_ready).
  - LOADED → DRAIN on start; step counter k is set to 0.
  - DRAIN → IDLE (or LOADED, see Configuration) after step LAST = DEPTH+CHANNELS-2 advances.
- load_ready = (state == IDLE), unless the Configuration macro is defined.
- start is ignored in IDLE and in DRAIN.
- Load and start in the same IDLE cycle: the load is accepted and the start is ignored.
- In DRAIN with en=1, for each lane c:
  - when 0 ≤ k−c < DEPTH: q[c] = tile[c][k−c] and q_valid[c] = 1;
  - otherwise q[c] = 0 and q_valid[c] = 0.
- In DRAIN with en=0: k holds, all q = 0, all q_valid = 0.
- Outside DRAIN: all q = 0, all q_valid = 0.
- k advances only when en=1. k is ⌈log2(DEPTH+CHANNELS−1)⌉ bits wide and never wraps; it is cleared on leaving DRAIN.
- done = 1 in the cycle where k == LAST and en = 1. The state leaves DRAIN on that edge.
- Reset, including mid-drain: tile storage = 0, k = 0, state = IDLE. All outputs are 0, including load_ready.
  - load_ready goes to 1 on the first cycle after rst_n deasserts.

## Timing
- A load handshake at edge t puts the state in LOADED at t+1.
- start sampled at edge t puts the state in DRAIN at t+1; q[0] = tile[0][0] is valid in that cycle if en = 1.
- Lane c's first valid element appears c enabled cycles after lane 0's.
- A drain takes DEPTH+CHANNELS−1 enabled cycles; stalls extend it 1:1.
- q, q_valid, busy and done are combinational from registered state, k and tile storage; there are no extra pipeline registers.
- A back-to-back tile needs at least 2 cycles after done (load, then start) without the Configuration macro.

## Configuration
- SKEW_FEEDER_DOUBLE_BUFFER_EN defined:
  - A shadow tile register is added.
  - load_ready is also 1 in LOADED and in DRAIN while the shadow is empty; such loads go to the shadow. In LOADED, the shadow is promoted when the drain completes.
  - On the final drain step with the shadow full: the shadow is promoted to the active tile, the state goes to LOADED, and done still pulses.
  - A start in that same cycle is ignored; the next start drains the promoted tile.
  - Reset clears the shadow.
- SKEW_FEEDER_DOUBLE_BUFFER_EN not defined: single tile storage; load_ready only in IDLE.

## Structure
- Package systolic_feeder_pkg holds:
  - the state enum typedef feeder_state_t {IDLE, LOADED, DRAIN};
  - a localparam function for LAST and the counter width.
- Sub-module skew_lane, one instance per channel:
  - holds DEPTH elements;
  - is given its lane index and step k;
  - outputs q and q_valid.
- Top level keeps the FSM, counter, handshake and the optional shadow.

## Test plan
Bench configuration: CHANNELS=4, DEPTH=4, BITS=8; tile[c][i] = 16c+i.
- Load, start, en held at 1 → drain lasts 7 cycles.
  - Cycle 0: q = {0,0,0,0} with q_valid = 0001, q[0] = 0.
  - Cycle 3: q = {3,18,33,48}, q_valid = 1111.
  - Cycle 6: q[3] = 51, valid = 1000, done = 1.
  - Next cycle: state IDLE.
- Negative elements (tile[1][*] = −128, −1, 127, 0) → q[1] shows the same signed values, no truncation.
- en=0 at cycles 2 and 3 of the drain → q = 0, valid = 0 on those cycles; the sequence resumes unchanged; done on the 9th cycle.
- rst_n pulsed low at drain cycle 3 → outputs 0 immediately; after release: IDLE, load_ready = 1, a start without a load is ignored.
- start in IDLE; load+start in the same cycle; load_valid during DRAIN → no drain begins, load_ready = 0 during DRAIN.
- With SKEW_FEEDER_DOUBLE_BUFFER_EN: second tile (tile+100) loaded at drain cycle 2 → at done, state LOADED; the next start drains the new values starting with 100.
